// File: rtl/ysyx_23060240_idu_pkg.sv
// rtl/ysyx_23060240_idu_pkg.sv - shared types and encodings for the decode stage
package ysyx_23060240_idu_pkg;

    typedef struct packed {
        logic [4:0] alu_func;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic       w_en;
        logic [1:0] w_sel;
        logic [2:0] branch_type;
        logic       mem_rd_en;
        logic [2:0] mem_rd_ctrl;
        logic       mem_wr_en;
        logic [1:0] mem_wr_ctrl;
        logic       jump_j;
        logic       jump_ecall;
        logic       jump_mret;
        logic       csr_en;
        logic       is_jal;
        logic       is_jalr;
    } idu_ctrl_t;

    localparam int CTRL_W = $bits(idu_ctrl_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } idu_state_e;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd13;
    localparam logic [4:0] ALU_LUI  = 5'd14;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    localparam logic [2:0] MRD_LB  = 3'd1;
    localparam logic [2:0] MRD_LBU = 3'd2;
    localparam logic [2:0] MRD_LH  = 3'd3;
    localparam logic [2:0] MRD_LHU = 3'd4;
    localparam logic [2:0] MRD_LW  = 3'd5;

    localparam logic [1:0] MWR_SB = 2'd1;
    localparam logic [1:0] MWR_SH = 2'd2;
    localparam logic [1:0] MWR_SW = 2'd3;

    localparam logic [1:0] WS_CSR = 2'b00;
    localparam logic [1:0] WS_PC4 = 2'b01;
    localparam logic [1:0] WS_ALU = 2'b10;
    localparam logic [1:0] WS_MEM = 2'b11;

    localparam logic       A_RS1 = 1'b0;
    localparam logic       A_PC  = 1'b1;
    localparam logic [1:0] B_RS2 = 2'd0;
    localparam logic [1:0] B_IMM = 2'd1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

endpackage

// File: rtl/ysyx_23060240_idu_if.sv
// rtl/ysyx_23060240_idu_if.sv - IFU-side and EXU-side handshake bundle of the decode stage
interface ysyx_23060240_idu_if
    import ysyx_23060240_idu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    idu_ctrl_t       out_ctrl;
    logic            out_illegal;
    logic            out_ebreak;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_ctrl, out_illegal, out_ebreak
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_ctrl, out_illegal, out_ebreak
    );
endinterface

// File: rtl/ysyx_23060240_idu_dec.sv
// rtl/ysyx_23060240_idu_dec.sv - combinational RV32I/M/Zicsr decoder
module ysyx_23060240_idu_dec
    import ysyx_23060240_idu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CSR = 1'b1
) (
    input  logic [31:0]     inst,
    output idu_ctrl_t       ctrl,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic            ebreak
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    idu_ctrl_t       c;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    always_comb begin
        c       = '0;
        imm     = '0;
        illegal = 1'b0;
        ebreak  = 1'b0;
        case (opcode)
            OP_LUI: begin
                imm = imm_u;
                c.alu_func = ALU_LUI; c.alu_b_sel = B_IMM;
                c.w_en = 1'b1; c.w_sel = WS_ALU;
            end
            OP_AUIPC: begin
                imm = imm_u;
                c.alu_a_sel = A_PC; c.alu_b_sel = B_IMM;
                c.w_en = 1'b1; c.w_sel = WS_ALU;
            end
            OP_JAL: begin
                imm = imm_j;
                c.alu_a_sel = A_PC; c.alu_b_sel = B_IMM;
                c.w_en = 1'b1; c.w_sel = WS_PC4; c.jump_j = 1'b1; c.is_jal = 1'b1;
            end
            OP_JALR: begin
                imm = imm_i;
                c.alu_a_sel = A_RS1; c.alu_b_sel = B_IMM;
                c.w_en = 1'b1; c.w_sel = WS_PC4; c.jump_j = 1'b1; c.is_jalr = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                imm = imm_b;
                c.alu_func = ALU_SUB; c.alu_b_sel = B_RS2;
                case (funct3)
                    3'b000:  c.branch_type = BR_BEQ;
                    3'b001:  c.branch_type = BR_BNE;
                    3'b100:  c.branch_type = BR_BLT;
                    3'b101:  c.branch_type = BR_BGE;
                    3'b110:  c.branch_type = BR_BLTU;
                    3'b111:  c.branch_type = BR_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                imm = imm_i;
                c.alu_b_sel = B_IMM; c.mem_rd_en = 1'b1;
                c.w_en = 1'b1; c.w_sel = WS_MEM;
                case (funct3)
                    3'b000:  c.mem_rd_ctrl = MRD_LB;
                    3'b100:  c.mem_rd_ctrl = MRD_LBU;
                    3'b001:  c.mem_rd_ctrl = MRD_LH;
                    3'b101:  c.mem_rd_ctrl = MRD_LHU;
                    3'b010:  c.mem_rd_ctrl = MRD_LW;
                    default: illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                imm = imm_s;
                c.alu_b_sel = B_IMM; c.mem_wr_en = 1'b1;
                case (funct3)
                    3'b000:  c.mem_wr_ctrl = MWR_SB;
                    3'b001:  c.mem_wr_ctrl = MWR_SH;
                    3'b010:  c.mem_wr_ctrl = MWR_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                imm = imm_i;
                c.alu_func = {2'b00, funct3}; c.alu_b_sel = B_IMM;
                c.w_en = 1'b1; c.w_sel = WS_ALU;
                // Shift-immediates reuse imm[11:5] as funct7; only srai may set bit 30.
                if (funct3 == 3'b001 && funct7 != 7'h00) begin
                    illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20)      c.alu_func = ALU_SRA;
                    else if (funct7 != 7'h00) illegal = 1'b1;
                end
            end
            OP_REG: begin
                c.alu_b_sel = B_RS2; c.w_en = 1'b1; c.w_sel = WS_ALU;
                if (funct7 == 7'h00)                          c.alu_func = {2'b00, funct3};
                else if (funct7 == 7'h20 && funct3 == 3'b000) c.alu_func = ALU_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'b101) c.alu_func = ALU_SRA;
                else if (funct7 == 7'h01 && EN_M)             c.alu_func = {2'b10, funct3};
                else                                          illegal = 1'b1;
            end
            OP_SYSTEM: begin
                imm = imm_i;
                if (inst == INST_EBREAK)                    ebreak = 1'b1;
                else if (!EN_CSR)                           illegal = 1'b1;
                else if (inst == INST_ECALL)                c.jump_ecall = 1'b1;
                else if (inst == INST_MRET)                 c.jump_mret = 1'b1;
                else if (funct3 == 3'b001 || funct3 == 3'b010) begin
                    c.csr_en = 1'b1; c.w_en = 1'b1; c.w_sel = WS_CSR;
                end else                                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        ctrl = illegal ? '0 : c;
    end
endmodule

// File: rtl/ysyx_23060240_idu_stage.sv
// rtl/ysyx_23060240_idu_stage.sv - registered decode stage with one-entry skid buffer and flush
module ysyx_23060240_idu_stage
    import ysyx_23060240_idu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CSR = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    ysyx_23060240_idu_if.slave  bus
);
    localparam int PW = 2 * XLEN + 15 + CTRL_W + 2;

    idu_ctrl_t       dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            dec_ebreak;
    logic [PW-1:0]   dec_pl;
    logic [PW-1:0]   main_q, main_d, skid_q, skid_d;
    idu_state_e      state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            accept;

    ysyx_23060240_idu_dec #(.XLEN(XLEN), .EN_M(EN_M), .EN_CSR(EN_CSR)) u_dec (
        .inst    (bus.in_inst),
        .ctrl    (dec_ctrl),
        .imm     (dec_imm),
        .illegal (dec_illegal),
        .ebreak  (dec_ebreak)
    );

    assign dec_pl = {bus.in_pc, dec_imm, bus.in_inst[19:15], bus.in_inst[24:20],
                     bus.in_inst[11:7], dec_ctrl, dec_illegal, dec_ebreak};

    assign {bus.out_pc, bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd,
            bus.out_ctrl, bus.out_illegal, bus.out_ebreak} = main_q;

    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.in_ready  = in_ready_q;
    assign accept        = bus.in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    main_d  = dec_pl;
                    state_d = ST_ONE;
                end
                ST_ONE: if (accept) begin
                    // Consume-and-accept replaces main in place; a stalled accept spills to skid.
                    if (bus.out_ready) begin
                        main_d = dec_pl;
                    end else begin
                        skid_d  = dec_pl;
                        state_d = ST_FULL;
                    end
                end else if (bus.out_ready) begin
                    state_d = ST_EMPTY;
                end
                ST_FULL: if (bus.out_ready) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end
endmodule

// File: tb/tb_ysyx_23060240_idu_stage.sv
// tb/tb_ysyx_23060240_idu_stage.sv - directed self-checking bench for the decode stage
module tb_ysyx_23060240_idu_stage;
    import ysyx_23060240_idu_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_vec;
    int   n_err;

    ysyx_23060240_idu_if #(.XLEN(32)) bus ();
    ysyx_23060240_idu_if #(.XLEN(32)) bus0 ();

    ysyx_23060240_idu_stage #(.XLEN(32), .EN_M(1'b1), .EN_CSR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
    );

    ysyx_23060240_idu_stage #(.XLEN(32), .EN_M(1'b0), .EN_CSR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0)
    );

    assign bus0.in_valid  = bus.in_valid;
    assign bus0.in_inst   = bus.in_inst;
    assign bus0.in_pc     = bus.in_pc;
    assign bus0.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.in_ready", bus.in_ready, 1);
        chk("rst.out_pc", bus.out_pc, 0);
        chk("rst.out_imm", bus.out_imm, 0);
        chk("rst.out_ctrl", bus.out_ctrl, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h0050_0093, 32'h8000_0000);
        chk("addi.valid", bus.out_valid, 1);
        chk("addi.pc", bus.out_pc, 32'h8000_0000);
        chk("addi.rd", bus.out_rd, 1);
        chk("addi.imm", bus.out_imm, 5);
        chk("addi.alu", bus.out_ctrl.alu_func, 0);
        chk("addi.w_en", bus.out_ctrl.w_en, 1);
        chk("addi.w_sel", bus.out_ctrl.w_sel, 2'b10);
        chk("addi.illegal", bus.out_illegal, 0);

        send(32'hFE20_AE23, 32'h8000_0004);
        chk("sw.imm", bus.out_imm, 32'hFFFF_FFFC);
        chk("sw.rs1", bus.out_rs1, 1);
        chk("sw.rs2", bus.out_rs2, 2);
        chk("sw.mem_wr_en", bus.out_ctrl.mem_wr_en, 1);
        chk("sw.mem_wr_ctrl", bus.out_ctrl.mem_wr_ctrl, 3);
        chk("sw.w_en", bus.out_ctrl.w_en, 0);

        send(32'h0220_81B3, 32'h8000_0008);
        chk("mul.alu", bus.out_ctrl.alu_func, 16);
        chk("mul.rd", bus.out_rd, 3);
        chk("mul.illegal", bus.out_illegal, 0);
        chk("mul_nom.valid", bus0.out_valid, 1);
        chk("mul_nom.illegal", bus0.out_illegal, 1);
        chk("mul_nom.ctrl", bus0.out_ctrl, 0);

        send(32'hFFFF_FFFF, 32'h8000_000C);
        chk("ones.illegal", bus.out_illegal, 1);
        chk("ones.ctrl", bus.out_ctrl, 0);

        send(32'h0010_0073, 32'h8000_0010);
        chk("ebreak.flag", bus.out_ebreak, 1);
        chk("ebreak.illegal", bus.out_illegal, 0);
        chk("ebreak.ctrl", bus.out_ctrl, 0);

        send(32'h0000_0073, 32'h8000_0014);
        chk("ecall.jump", bus.out_ctrl.jump_ecall, 1);
        chk("ecall.illegal", bus.out_illegal, 0);
        chk("ecall_nocsr.illegal", bus0.out_illegal, 1);

        send(32'h0080_00EF, 32'h8000_0018);
        chk("jal.imm", bus.out_imm, 8);
        chk("jal.w_sel", bus.out_ctrl.w_sel, 2'b01);
        chk("jal.is_jal", bus.out_ctrl.is_jal, 1);
        chk("jal.jump_j", bus.out_ctrl.jump_j, 1);

        send(32'h4030_D093, 32'h8000_001C);
        chk("srai.alu", bus.out_ctrl.alu_func, 13);
        chk("srai.illegal", bus.out_illegal, 0);
        send(32'h2030_D093, 32'h8000_0020);
        chk("srbad.illegal", bus.out_illegal, 1);
        @(negedge clk);
        chk("drain.valid", bus.out_valid, 0);

        bus.out_ready = 1'b0;
        drive(32'h0010_0093, 32'h100);
        @(negedge clk);
        chk("bp1.in_ready", bus.in_ready, 1);
        chk("bp1.pc", bus.out_pc, 32'h100);
        drive(32'h0020_0113, 32'h104);
        @(negedge clk);
        chk("bp2.in_ready", bus.in_ready, 0);
        drive(32'h0030_0193, 32'h108);
        @(negedge clk);
        chk("bp3.valid", bus.out_valid, 1);
        chk("bp3.pc_stable", bus.out_pc, 32'h100);
        chk("bp3.in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp4.pc", bus.out_pc, 32'h104);
        chk("bp4.imm", bus.out_imm, 2);
        chk("bp4.in_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("bp5.pc", bus.out_pc, 32'h108);
        chk("bp5.rd", bus.out_rd, 3);
        drive(32'h0040_0213, 32'h10C);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp6.pc", bus.out_pc, 32'h10C);
        chk("bp6.imm", bus.out_imm, 4);
        @(negedge clk);
        chk("bp7.valid", bus.out_valid, 0);

        bus.out_ready = 1'b0;
        drive(32'h0050_0293, 32'h200);
        @(negedge clk);
        drive(32'h0060_0313, 32'h204);
        @(negedge clk);
        chk("fl.full", bus.in_ready, 0);
        flush = 1'b1;
        drive(32'h0070_0393, 32'h208);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl.valid", bus.out_valid, 0);
        chk("fl.in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("fl.still_empty", bus.out_valid, 0);
        send(32'h0080_0413, 32'h20C);
        chk("fl.next.valid", bus.out_valid, 1);
        chk("fl.next.pc", bus.out_pc, 32'h20C);
        @(negedge clk);
        chk("fl.next.gone", bus.out_valid, 0);

        bus.out_ready = 1'b0;
        drive(32'h0090_0493, 32'h300);
        @(negedge clk);
        drive(32'h00A0_0513, 32'h304);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rs.full_valid", bus.out_valid, 1);
        chk("rs.full_ready", bus.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rs.async_valid", bus.out_valid, 0);
        chk("rs.async_pc", bus.out_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs.in_ready", bus.in_ready, 1);
        chk("rs.valid", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_23060240_idu_stage.md
# ysyx_23060240_idu_stage

Registered, handshaked instruction-decode stage sitting between the IFU and EXU of the NPC core. It is the parametrised successor of the combinational decoder. It adds XLEN-wide immediate generation, optional RV32M decode, illegal-instruction detection and an `ebreak` flag. A valid/ready pipeline register with a one-entry skid buffer sustains one instruction per cycle under backpressure and supports a synchronous flush for redirects.

## Interface
- `XLEN`, 32: width of PC and immediate; immediates are sign-extended to XLEN.
- `EN_M`, 1: 1 decodes RV32M (mul/mulh/mulhsu/mulhu/div/divu/rem/remu); 0 flags them illegal.
- `EN_CSR`, 1: 1 decodes csrrw/csrrs/ecall/mret; 0 flags them illegal.
- `clk  in  1  core clock`
- `rst_n  in  1  asynchronous, active-low reset`
- `flush  in  1  discard all held and incoming instructions this cycle`
- `in_valid  in  1  IFU offers an instruction`
- `in_ready  out  1  stage accepts (registered)`
- `in_inst  in  32  raw instruction`
- `in_pc  in  XLEN  instruction PC`
- `out_valid  out  1  decoded instruction available`
- `out_ready  in  1  EXU consumes`
- `out_pc  out  XLEN  passed-through PC`
- `out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J per format, 0 for R)`
- `out_rs1, out_rs2, out_rd  out  5 each  register indices`
- `out_ctrl  out  CTRL_W  packed control word (idu_ctrl_t)`
- `out_illegal  out  1  no legal RV32I/M/Zicsr match`
- `out_ebreak  out  1  instruction is ebreak (0x00100073)`

## Operation
- Decode is combinational on `in_inst`; the result, with PC, is captured in the output register on acceptance (`in_valid && in_ready`).
- Control word fields: `alu_func[4:0]`, `alu_a_sel`, `alu_b_sel[1:0]`, `w_en`, `w_sel[1:0]`, `branch_type[2:0]`, `mem_rd_en`, `mem_rd_ctrl[2:0]`, `mem_wr_en`, `mem_wr_ctrl[1:0]`, `jump_j`, `jump_ecall`, `jump_mret`, `csr_en`, `is_jal`, `is_jalr`.
- `alu_func` codes 0–14 are the existing ALU encodings: add 0, sll 1, slt 2, sltu 3, xor 4, srl 5, or 6, and 7, sub 8, sra 13, lui 14. M ops use 16–23, in the order mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- `mem_wr_ctrl`: sb=1, sh=2, sw=3. `mem_rd_ctrl`: lb=1, lbu=2, lh=3, lhu=4, lw=5. `branch_type`: beq..bgeu = 1..6, else 0. `w_sel`: 01 pc+4, 10 ALU, 11 mem, 00 csr/none.
- Illegal instruction:
  - `out_illegal`=1 and the whole control word is forced to 0 (no write, no memory, no jump).
  - Covers unknown opcode or funct3/funct7, shift-immediates with funct7 other than 0x00/0x20, and a disabled extension.
- `ebreak` is legal: `out_ebreak`=1, all other control bits 0.
- Buffering:
  - Two slots: the output register (main) and a skid register.
  - Accept while main is full and `out_ready`=0 → the instruction goes to skid.
  - `in_ready` = !skid_valid, registered.
  - When main is consumed, skid moves to main in the same edge.
- States (main_v, skid_v): EMPTY(0,0), ONE(1,0), FULL(1,1). FULL is only entered from ONE via accept with !out_ready. FULL→ONE on out_ready; an accept cannot occur in FULL.

## Timing
- Reset (async assert, sync release): `out_valid`=0, `in_ready`=1, all data outputs 0, both slots invalid.
- Latency: 1 cycle from accepted input to `out_valid`. Throughput: 1 instruction/cycle when `out_ready`=1.
- Outputs are stable while `out_valid && !out_ready`.
- `flush`=1:
  - Next cycle both slots are invalid, `out_valid`=0 and `in_ready`=1.
  - An `in_valid` in the flush cycle is dropped.
  - Flush has priority over accept and consume.
- Simultaneous consume and accept in ONE: the new instruction replaces main and there is no bubble.
- Reset mid-operation discards both slots immediately.

## Structure
- Package `ysyx_23060240_idu_pkg` holds `idu_ctrl_t` (packed), `CTRL_W`, the alu_func/branch/mem/w_sel constants, and opcode localparams.
- One sub-module, `ysyx_23060240_idu_dec`: the pure combinational decoder (inst → ctrl, imm, illegal, ebreak) parametrised by XLEN/EN_M/EN_CSR. The stage holds only the buffering and FSM.

## Test plan
- `addi x1,x0,5` (0x00500093) → 1 cycle later: `out_valid`=1, rd=1, imm=5, alu_func=0, w_en=1, w_sel=10, illegal=0.
- `sw x2,-4(x1)` (0xFE20AE23) → imm=0xFFFFFFFC, rs1=1, rs2=2, mem_wr_en=1, mem_wr_ctrl=3, w_en=0.
- `mul x3,x1,x2` (0x022081B3) → with EN_M=1: alu_func=16, rd=3. With EN_M=0: illegal=1, ctrl=0. Also check 0xFFFFFFFF → illegal=1 and 0x00100073 → ebreak=1.
- Backpressure: 4 back-to-back instructions with `out_ready` low for 3 cycles → `in_ready` falls after the 2nd accept; all 4 emerge in order with no loss or duplication.
- Flush while FULL, with `in_valid` also high → next cycle `out_valid`=0, `in_ready`=1; the flushed and incoming instructions never appear.
- Assert `rst_n` low while FULL → `out_valid` is 0 immediately (asynchronously), `in_ready`=1 after release.
